ifid_skid_buffer: RTL
=====================

Name: ifid_skid_buffer

Overview:
Parametrised IF/ID pipeline buffer for the 16-bit CPU. It replaces the single-register IF/ID stage with a DEPTH-entry FIFO carrying {opcode, one, two, three, PC}. It adds valid/ready handshakes, hazard stall, flush with bubble insertion, and a saturating stall counter. It sits between fetch and decode.

Parameters:
OPW, 4, opcode field width
REGW, 4, width of each operand field one/two/three
PCW, 16, program counter width
DEPTH, 2, entries in the buffer (>=1; non-power-of-two allowed)
NOP_OP, 0, opcode driven on opcode_o when the buffer is empty (bubble)
CNTW, 8, stall counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
in_valid  in  1  fetch presents an instruction
in_ready  out  1  buffer can accept this cycle
opcode  in  OPW  fetched opcode
one  in  REGW  operand field 1
two  in  REGW  operand field 2
three  in  REGW  operand field 3
PC  in  PCW  PC of the fetched instruction
hazard  in  1  decode stall; blocks dequeue
flush  in  1  branch/jump flush; empties the buffer
out_valid  out  1  head entry valid
out_ready  in  1  decode accepts the head
opcode_o  out  OPW  head opcode, or NOP_OP when empty
one_o  out  REGW  head field 1, or 0 when empty
two_o  out  REGW  head field 2, or 0 when empty
three_o  out  REGW  head field 3, or 0 when empty
PC_o  out  PCW  head PC, or 0 when empty
count_o  out  $clog2(DEPTH+1)  current occupancy
stall_cnt_o  out  CNTW  saturating count of stalled cycles

Behaviour:
- Reset (async, active-high):
  - wr_ptr, rd_ptr and count clear to 0; stall_cnt clears to 0; storage contents are don't-care.
  - Outputs during and after reset: out_valid=0, opcode_o=NOP_OP, one_o/two_o/three_o=0, PC_o=0, count_o=0, stall_cnt_o=0.
  - in_ready=1 after reset release, because in_ready is derived from count.
- Handshake qualifiers:
  - enq = in_valid & in_ready & ~flush.
  - deq = out_valid & out_ready & ~hazard.
- in_ready = (count < DEPTH). It is combinational from registered count and does not depend on same-cycle deq, so it is 0 whenever the buffer is full.
- out_valid = (count != 0).
- Output fields are a mux of the storage entry at rd_ptr when count != 0, otherwise the bubble values. There is no combinational path from the inputs to the outputs.
- Latency: an instruction enqueued at edge N appears on the outputs after edge N, i.e. one cycle. There is no bypass, even when the buffer is empty.
- Ordering is strict FIFO. Each pointer increments on its operation and wraps from DEPTH-1 to 0.
- Occupancy on each edge:
  - count += enq - deq.
  - Simultaneous enq and deq (possible only when 0 < count < DEPTH) leaves count unchanged; both pointers advance.
- in_valid while full: the instruction is ignored. Fetch must hold it until in_ready.
- hazard=1: no dequeue regardless of out_ready. Outputs hold the head stably. Enqueue continues while space remains.
- flush=1 (synchronous, highest priority after reset):
  - On the edge, count, wr_ptr and rd_ptr go to 0.
  - Any same-cycle in_valid is dropped and no dequeue is counted.
  - Next cycle: out_valid=0 and outputs are the bubble values.
  - flush together with hazard: flush wins.
- stall_cnt increments on each edge where out_valid & hazard & ~flush. It saturates at 2^CNTW-1 and is cleared only by reset.
- DEPTH=1 degenerates to a registered stage with valid: in_ready=~out_valid.

Test Plan:
- Reset mid-stream: load 2 entries, assert reset asynchronously between edges -> outputs go immediately to out_valid=0, opcode_o=0, PC_o=0, count_o=0; in_ready=1 after release.
- Basic pass-through (DEPTH=2): enqueue {opcode=2, one=3, two=4, three=5, PC=15} with out_ready=1 -> after 1 edge opcode_o=2, PC_o=15, out_valid=1; after the next edge (no new input) out_valid=0, opcode_o=0.
- Fill and order: out_ready=0, enqueue PC=15 then PC=17; a third in_valid with PC=19 -> in_ready=0, count_o=2. Then out_ready=1 -> PC_o sequence is 15, 17, then 19 after it is accepted.
- Hazard stall: buffer holds PC=17, hazard=1 and out_ready=1 for 3 cycles -> PC_o holds 17, count_o is unchanged, stall_cnt_o=3. Drop hazard -> dequeue on the next edge.
- Flush priority: count=2, flush=1 with in_valid=1 (PC=21) and hazard=1 -> next cycle count_o=0, out_valid=0, opcode_o=NOP_OP; PC=21 never appears.
- Wrap-around (DEPTH=3): stream 7 instructions with continuous enq and deq -> outputs are in order with PCs 1..7; count_o stays at 1; pointers wrap twice without loss.

Source files
------------

// File: rtl/ifid_skid_buffer.sv
// ---------------------------------------------------------------------------
// ifid_skid_buffer
//
// IF/ID pipeline buffer for the 16-bit CPU. It is a DEPTH-entry FIFO that
// sits between fetch and decode. Each entry carries {opcode, one, two,
// three, PC}. It has valid/ready handshakes on both sides, a hazard stall
// that blocks dequeue, a flush that empties the buffer and inserts a
// bubble, and a saturating counter of stalled cycles.
//
// Ports
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   in_valid/in_ready   fetch-side handshake
//   opcode,one,two,
//   three,PC            fetched instruction fields
//   hazard              decode stall; no dequeue while set
//   flush               synchronous flush; drops everything, including
//                       a same-cycle input
//   out_valid/out_ready decode-side handshake
//   opcode_o..PC_o      head entry, or bubble values when empty
//   count_o             current occupancy
//   stall_cnt_o         saturating count of cycles stalled by hazard
// ---------------------------------------------------------------------------
module ifid_skid_buffer #(
    parameter int OPW    = 4,
    parameter int REGW   = 4,
    parameter int PCW    = 16,
    parameter int DEPTH  = 2,
    parameter int NOP_OP = 0,
    parameter int CNTW   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OPW-1:0]               opcode,
    input  logic [REGW-1:0]              one,
    input  logic [REGW-1:0]              two,
    input  logic [REGW-1:0]              three,
    input  logic [PCW-1:0]               PC,
    input  logic                         hazard,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OPW-1:0]               opcode_o,
    output logic [REGW-1:0]              one_o,
    output logic [REGW-1:0]              two_o,
    output logic [REGW-1:0]              three_o,
    output logic [PCW-1:0]               PC_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [CNTW-1:0]              stall_cnt_o
);

    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PTRW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WORDW = OPW + 3 * REGW + PCW;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        return (&c) ? c : c + CNTW'(1);
    endfunction

    logic [WORDW-1:0] mem_p0 [DEPTH];
    logic [PTRW-1:0]  wr_ptr_p0;
    logic [PTRW-1:0]  rd_ptr_p0;
    logic [CW-1:0]    count_p0;
    logic [CNTW-1:0]  stall_cnt_p0;

    logic enq;
    logic deq;
    logic [WORDW-1:0] in_word;
    logic [WORDW-1:0] head_word;

    // Ready/valid are derived from registered occupancy only, so in_ready
    // is low whenever full even if decode is draining this cycle.
    assign in_ready  = (count_p0 < CW'(DEPTH));
    assign out_valid = (count_p0 != '0);

    assign enq = in_valid & in_ready & ~flush;
    assign deq = out_valid & out_ready & ~hazard;

    assign in_word = {opcode, one, two, three, PC};

    // ---- stage p0: storage write, pointers, occupancy, stall counter ----
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_p0[wr_ptr_p0] <= in_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_p0    <= '0;
            rd_ptr_p0    <= '0;
            count_p0     <= '0;
            stall_cnt_p0 <= '0;
        end else begin
            if (flush) begin
                wr_ptr_p0 <= '0;
                rd_ptr_p0 <= '0;
                count_p0  <= '0;
            end else begin
                if (enq) begin
                    wr_ptr_p0 <= ptr_next(wr_ptr_p0);
                end
                if (deq) begin
                    rd_ptr_p0 <= ptr_next(rd_ptr_p0);
                end
                if (enq && !deq) begin
                    count_p0 <= count_p0 + CW'(1);
                end else if (!enq && deq) begin
                    count_p0 <= count_p0 - CW'(1);
                end
            end
            if (out_valid && hazard && !flush) begin
                stall_cnt_p0 <= sat_inc(stall_cnt_p0);
            end
        end
    end

    // ---- output: head entry or bubble, from registered state only ----
    assign head_word = mem_p0[rd_ptr_p0];

    always_comb begin
        opcode_o = OPW'(NOP_OP);
        one_o    = '0;
        two_o    = '0;
        three_o  = '0;
        PC_o     = '0;
        if (out_valid) begin
            {opcode_o, one_o, two_o, three_o, PC_o} = head_word;
        end
    end

    assign count_o     = count_p0;
    assign stall_cnt_o = stall_cnt_p0;

endmodule
